wb_demux_1t2: RTL and testbench

- Registered 1-to-2 data router, the counterpart of the 2-to-1 operand select: one 32-bit producer stream is steered to one of two consumers (e.g. CPU store path to VRAM vs. peripheral/GPIO bus).
- Valid/ready handshakes on all three sides, with a one-entry holding register.
- Per-consumer 16-bit transfer counters for debug readout.

---
 rtl/wb_demux_1t2_pkg.sv | 14 +
 rtl/wb_demux_1t2_xfer_counter.sv | 23 ++
 rtl/wb_demux_1t2.sv | 88 ++++++++
 tb/tb_wb_demux_1t2.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_demux_1t2_pkg.sv
// rtl/wb_demux_1t2_pkg.sv - shared state encoding and default widths for the 1-to-2 router
package wb_demux_1t2_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 16;

    // Holding-register occupancy. The code 2'b11 is unused and recovers to EMPTY.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        HOLD0 = 2'b01,
        HOLD1 = 2'b10
    } state_t;

endpackage

// File: rtl/wb_demux_1t2_xfer_counter.sv
// rtl/wb_demux_1t2_xfer_counter.sv - free-running wrapping transfer counter
// Ports: clk, rst (async, active-high), inc (count one transfer), count (current value).
module xfer_counter
    import wb_demux_1t2_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Wraps modulo 2^CNT_W by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/wb_demux_1t2.sv
// rtl/wb_demux_1t2.sv - registered 1-to-2 data router with one-entry holding register
// Ports: clk, rst (async, active-high);
//        producer in_valid/in_sel/in_data -> in_ready;
//        consumer 0 out0_valid/out0_ready, consumer 1 out1_valid/out1_ready,
//        shared out_data; cnt0/cnt1 completed-transfer counters.
module wb_demux_1t2
    import wb_demux_1t2_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    state_t state;
    state_t next_state;
    logic   drain0;
    logic   drain1;
    logic   drain;
    logic   accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        drain0     = (state == HOLD0) && out0_ready;
        drain1     = (state == HOLD1) && out1_ready;
        drain      = drain0 || drain1;
        // Draining frees the slot in the same cycle, so a new word can enter with no bubble.
        in_ready   = (state == EMPTY) || drain;
        accept     = in_valid && in_ready;
        next_state = state;
        case (state)
            EMPTY, HOLD0, HOLD1: begin
                if (accept) begin
                    next_state = in_sel ? HOLD1 : HOLD0;
                end else if (drain) begin
                    next_state = EMPTY;
                end
            end
            default: next_state = EMPTY;
        endcase
    end

    // Data is loaded only on accept; it keeps its last value after a drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= '0;
        end else if (accept) begin
            out_data <= in_data;
        end
    end

    assign out0_valid = (state == HOLD0);
    assign out1_valid = (state == HOLD1);

    xfer_counter #(.CNT_W(CNT_W)) u_cnt0 (
        .clk   (clk),
        .rst   (rst),
        .inc   (drain0),
        .count (cnt0)
    );

    xfer_counter #(.CNT_W(CNT_W)) u_cnt1 (
        .clk   (clk),
        .rst   (rst),
        .inc   (drain1),
        .count (cnt1)
    );

endmodule

// File: tb/tb_wb_demux_1t2.sv
// tb/tb_wb_demux_1t2.sv - directed self-checking bench for wb_demux_1t2
module tb_wb_demux_1t2;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_sel;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out0_valid;
    logic        out0_ready;
    logic        out1_valid;
    logic        out1_ready;
    logic [31:0] out_data;
    logic [15:0] cnt0;
    logic [15:0] cnt1;

    int total;
    int bad;

    wb_demux_1t2 dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out_data   (out_data),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_sel     = 1'b0;
        in_data    = '0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        tick();
        chk("rst_out0_valid", {31'd0, out0_valid}, 32'd0);
        chk("rst_out1_valid", {31'd0, out1_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_cnt0", {16'd0, cnt0}, 32'd0);
        chk("rst_cnt1", {16'd0, cnt1}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Single word to consumer 0
        in_valid   = 1'b1;
        in_sel     = 1'b0;
        in_data    = 32'hDEADBEEF;
        out0_ready = 1'b1;
        #1;
        chk("t1_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        in_data  = 32'h0;
        chk("t1_out0_valid", {31'd0, out0_valid}, 32'd1);
        chk("t1_out1_valid", {31'd0, out1_valid}, 32'd0);
        chk("t1_out_data", out_data, 32'hDEADBEEF);
        chk("t1_cnt0_pre", {16'd0, cnt0}, 32'd0);
        tick();
        chk("t1_out0_valid_end", {31'd0, out0_valid}, 32'd0);
        chk("t1_cnt0", {16'd0, cnt0}, 32'd1);
        chk("t1_cnt1", {16'd0, cnt1}, 32'd0);
        chk("t1_empty_in_ready", {31'd0, in_ready}, 32'd1);
        chk("t1_out_data_held", out_data, 32'hDEADBEEF);

        // Back-pressure on consumer 1, then drain and accept together
        out1_ready = 1'b0;
        in_valid   = 1'b1;
        in_sel     = 1'b1;
        in_data    = 32'h12345678;
        tick();
        in_sel  = 1'b0;
        in_data = 32'hAAAA5555;
        for (int i = 0; i < 5; i++) begin
            chk("t2_in_ready_blocked", {31'd0, in_ready}, 32'd0);
            chk("t2_out_data_stable", out_data, 32'h12345678);
            chk("t2_out1_valid", {31'd0, out1_valid}, 32'd1);
            chk("t2_out0_valid", {31'd0, out0_valid}, 32'd0);
            tick();
        end
        out1_ready = 1'b1;
        #1;
        chk("t2_in_ready_on_drain", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("t2_out_data_new", out_data, 32'hAAAA5555);
        chk("t2_out0_valid_new", {31'd0, out0_valid}, 32'd1);
        chk("t2_out1_valid_new", {31'd0, out1_valid}, 32'd0);
        chk("t2_cnt1", {16'd0, cnt1}, 32'd1);
        chk("t2_cnt0_pre", {16'd0, cnt0}, 32'd1);
        tick();
        chk("t2_cnt0", {16'd0, cnt0}, 32'd2);
        chk("t2_empty", {30'd0, out1_valid, out0_valid}, 32'd0);

        // Streaming alternation, one word per cycle
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_sel   = i[0];
            in_data  = 32'h100 + i;
            #1;
            chk("t3_in_ready", {31'd0, in_ready}, 32'd1);
            tick();
            chk("t3_out_data", out_data, 32'h100 + i);
            chk("t3_out0_valid", {31'd0, out0_valid}, {31'd0, ~i[0]});
            chk("t3_out1_valid", {31'd0, out1_valid}, {31'd0, i[0]});
        end
        in_valid = 1'b0;
        tick();
        chk("t3_cnt0", {16'd0, cnt0}, 32'd6);
        chk("t3_cnt1", {16'd0, cnt1}, 32'd5);
        chk("t3_empty", {30'd0, out1_valid, out0_valid}, 32'd0);

        // Counter wrap: 65529 more consumer-0 transfers bring cnt0 from 6 to 0xFFFF
        in_valid = 1'b1;
        in_sel   = 1'b0;
        in_data  = 32'h0F0F0F0F;
        for (int i = 0; i < 65529; i++) begin
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("t4_cnt0_max", {16'd0, cnt0}, 32'h0000FFFF);
        chk("t4_cnt1_max", {16'd0, cnt1}, 32'd5);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("t4_cnt0_wrap", {16'd0, cnt0}, 32'h00000000);
        chk("t4_cnt1_wrap", {16'd0, cnt1}, 32'd5);

        // Asynchronous reset while a word is held for consumer 1
        out1_ready = 1'b0;
        in_valid   = 1'b1;
        in_sel     = 1'b1;
        in_data    = 32'hCAFEF00D;
        tick();
        in_valid = 1'b0;
        chk("t5_out1_valid_pre", {31'd0, out1_valid}, 32'd1);
        chk("t5_cnt1_pre", {16'd0, cnt1}, 32'd5);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_out1_valid_async", {31'd0, out1_valid}, 32'd0);
        chk("t5_out0_valid_async", {31'd0, out0_valid}, 32'd0);
        chk("t5_out_data_async", out_data, 32'd0);
        chk("t5_cnt0_async", {16'd0, cnt0}, 32'd0);
        chk("t5_cnt1_async", {16'd0, cnt1}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("t5_in_ready_release", {31'd0, in_ready}, 32'd1);
        tick();
        chk("t5_word_dropped", {30'd0, out1_valid, out0_valid}, 32'd0);
        chk("t5_cnt1_dropped", {16'd0, cnt1}, 32'd0);

        // Wrong consumer ready: consumer 1 ready must not drain a consumer-0 word
        out0_ready = 1'b0;
        out1_ready = 1'b1;
        in_valid   = 1'b1;
        in_sel     = 1'b0;
        in_data    = 32'h5A5A0001;
        tick();
        in_valid = 1'b0;
        in_sel   = 1'b1;
        in_data  = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            chk("t6_out1_valid", {31'd0, out1_valid}, 32'd0);
            chk("t6_out0_valid", {31'd0, out0_valid}, 32'd1);
            chk("t6_out_data", out_data, 32'h5A5A0001);
            chk("t6_cnt1", {16'd0, cnt1}, 32'd0);
            chk("t6_in_ready", {31'd0, in_ready}, 32'd0);
            tick();
        end
        out0_ready = 1'b1;
        tick();
        chk("t6_cnt0_drain", {16'd0, cnt0}, 32'd1);
        chk("t6_cnt1_final", {16'd0, cnt1}, 32'd0);
        chk("t6_empty", {30'd0, out1_valid, out0_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
